// File: rtl/dcache_snoop_agent_pkg.sv
// Shared definitions for the data-cache snoop agent: FSM states and address field layout.
package dcache_snoop_agent_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned BYTE_LSB   = 0;
  localparam int unsigned BYTE_W     = 2;
  localparam int unsigned WORD_LSB   = 2;
  localparam int unsigned IDX_LSB    = 3;
  localparam int unsigned BLK_WORDS  = 2;
  localparam int unsigned BLK_ADDR_W = ADDR_W - IDX_LSB;
  localparam int unsigned CNT_W      = 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SUPPLY = 2'd1,
    S_UPDATE = 2'd2,
    S_DONE   = 2'd3
  } snp_state_e;

  // Tag width once the index has taken its bits out of the block address.
  function automatic int unsigned tag_width(input int unsigned idxw);
    return BLK_ADDR_W - idxw;
  endfunction

endpackage

// File: rtl/dcache_snoop_agent_lookup.sv
// Combinational snoop lookup: hit, lowest hitting way and its dirty state.
module dcache_snoop_agent_lookup #(
  parameter int unsigned WAYS = 2,
  parameter int unsigned TAGW = 26,
  parameter int unsigned WAYW = 1
) (
  input  logic [TAGW-1:0]      tag_i,
  input  logic [WAYS*TAGW-1:0] way_tag_i,
  input  logic [WAYS-1:0]      way_valid_i,
  input  logic [WAYS-1:0]      way_dirty_i,
  output logic                 hit_o,
  output logic [WAYW-1:0]      hway_o,
  output logic                 mod_o
);

  // Scan from the highest way down so the lowest matching way wins.
  always_comb begin
    hit_o  = 1'b0;
    hway_o = '0;
    mod_o  = 1'b0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (way_valid_i[w] && (way_tag_i[w*TAGW +: TAGW] == tag_i)) begin
        hit_o  = 1'b1;
        hway_o = WAYW'(w);
        mod_o  = way_dirty_i[w];
      end
    end
  end

endmodule

// File: rtl/dcache_snoop_agent.sv
// Cache-side coherence agent: forwards own bus requests, answers snoops,
// supplies dirty blocks and downgrades snooped frames.
module dcache_snoop_agent
  import dcache_snoop_agent_pkg::*;
#(
  parameter int unsigned SETS = 8,
  parameter int unsigned WAYS = 2,
  localparam int unsigned IDXW = $clog2(SETS),
  localparam int unsigned WAYW = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int unsigned TAGW = tag_width(IDXW)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   req_trans,
  input  logic                   req_write,
  output logic                   cctrans,
  output logic                   ccwrite,
  input  logic                   ccwait,
  input  logic                   ccinv,
  input  logic [31:0]            ccsnoopaddr,
  input  logic                   dwait,
  output logic [31:0]            dstore,
  output logic [IDXW-1:0]        snp_idx,
  input  logic [WAYS*TAGW-1:0]   way_tag,
  input  logic [WAYS-1:0]        way_valid,
  input  logic [WAYS-1:0]        way_dirty,
  input  logic [WAYS*2*32-1:0]   way_data,
  output logic                   upd_en,
  output logic [IDXW-1:0]        upd_idx,
  output logic [WAYW-1:0]        upd_way,
  output logic                   upd_valid,
  output logic                   snp_busy,
  input  logic                   link_valid,
  input  logic [31:0]            link_addr,
  output logic                   link_clr
);

  localparam int unsigned TAG_LSB = IDX_LSB + IDXW;

  snp_state_e            state_q, state_d;
  logic [BLK_ADDR_W-1:0] blk_q, blk_d;
  logic [WAYW-1:0]       way_q, way_d;
  logic                  inv_q, inv_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  hit;
  logic [WAYW-1:0]       hway;
  logic                  mod;
  logic                  link_match_snp;
  logic                  link_match_lat;
  logic [WAYW:0]         word_sel;
  logic                  unused_addr_bits;

  dcache_snoop_agent_lookup #(
    .WAYS (WAYS),
    .TAGW (TAGW),
    .WAYW (WAYW)
  ) u_lookup (
    .tag_i       (ccsnoopaddr[ADDR_W-1:TAG_LSB]),
    .way_tag_i   (way_tag),
    .way_valid_i (way_valid),
    .way_dirty_i (way_dirty),
    .hit_o       (hit),
    .hway_o      (hway),
    .mod_o       (mod)
  );

  // Once a snoop is accepted the frame arrays are read at the latched set.
  assign snp_idx = (state_q == S_IDLE) ? ccsnoopaddr[IDX_LSB +: IDXW] : blk_q[IDXW-1:0];

  assign link_match_snp = (link_addr[ADDR_W-1:IDX_LSB] == ccsnoopaddr[ADDR_W-1:IDX_LSB]);
  assign link_match_lat = (link_addr[ADDR_W-1:IDX_LSB] == blk_q);
  assign word_sel       = {way_q, ccsnoopaddr[WORD_LSB]};

  // Byte offsets never participate in block matching.
  assign unused_addr_bits = ^{ccsnoopaddr[BYTE_LSB +: BYTE_W], link_addr[IDX_LSB-1:0]};

  // State and snoop context registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      blk_q   <= '0;
      way_q   <= '0;
      inv_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      way_q   <= way_d;
      inv_q   <= inv_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; an early ccwait drop in SUPPLY still downgrades the frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (ccwait) begin
          if (mod)                state_d = S_SUPPLY;
          else if (hit && ccinv)  state_d = S_UPDATE;
          else                    state_d = S_DONE;
        end
      end
      S_SUPPLY: begin
        if (!ccwait || (!dwait && (cnt_q == CNT_W'(BLK_WORDS - 1))))
          state_d = S_UPDATE;
      end
      S_UPDATE: state_d = S_DONE;
      S_DONE: begin
        if (!ccwait) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Snoop context capture, invalidate accumulation and accepted-word count.
  always_comb begin
    blk_d = blk_q;
    way_d = way_q;
    inv_d = inv_q;
    cnt_d = cnt_q;
    if (state_q == S_IDLE) begin
      if (ccwait) begin
        blk_d = ccsnoopaddr[ADDR_W-1:IDX_LSB];
        way_d = hway;
        inv_d = ccinv;
        cnt_d = '0;
      end
    end else if (state_q == S_SUPPLY) begin
      inv_d = inv_q | ccinv;
      if (ccwait && !dwait) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Bus, data and frame-update outputs decoded from state and live inputs.
  always_comb begin
    cctrans   = req_trans;
    ccwrite   = req_write && !ccwait;
    dstore    = '0;
    upd_en    = 1'b0;
    upd_idx   = blk_q[IDXW-1:0];
    upd_way   = way_q;
    upd_valid = 1'b0;
    snp_busy  = 1'b0;
    link_clr  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ccwait && mod) ccwrite = 1'b1;
        if (ccwait && !hit && ccinv && link_valid && link_match_snp) link_clr = 1'b1;
      end
      S_SUPPLY: begin
        ccwrite  = 1'b1;
        snp_busy = 1'b1;
        dstore   = way_data[32'(word_sel) * DATA_W +: DATA_W];
      end
      S_UPDATE: begin
        snp_busy  = 1'b1;
        upd_en    = 1'b1;
        upd_valid = !inv_q;
        link_clr  = link_valid && inv_q && link_match_lat;
      end
      S_DONE: ;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dcache_snoop_agent.sv
// Self-checking bench for dcache_snoop_agent with a frame-array and link model.
module tb_dcache_snoop_agent;

  localparam int unsigned SETS = 8;
  localparam int unsigned WAYS = 2;
  localparam int unsigned IDXW = 3;
  localparam int unsigned WAYW = 1;
  localparam int unsigned TAGW = 26;

  logic                 CLK, RST;
  logic                 req_trans, req_write, cctrans, ccwrite;
  logic                 ccwait, ccinv, dwait;
  logic [31:0]          ccsnoopaddr, dstore, link_addr;
  logic [IDXW-1:0]      snp_idx, upd_idx;
  logic [WAYS*TAGW-1:0] way_tag;
  logic [WAYS-1:0]      way_valid, way_dirty;
  logic [WAYS*64-1:0]   way_data;
  logic                 upd_en, upd_valid, snp_busy, link_valid, link_clr;
  logic [WAYW-1:0]      upd_way;

  logic [TAGW-1:0] f_tag   [SETS][WAYS];
  logic            f_valid [SETS][WAYS];
  logic            f_dirty [SETS][WAYS];
  logic [31:0]     f_data  [SETS][WAYS][2];
  logic [2:0]      cur_set;

  int n_cmp = 0;
  int n_mis = 0;

  dcache_snoop_agent #(.SETS(SETS), .WAYS(WAYS)) dut (
    .CLK(CLK), .RST(RST), .req_trans(req_trans), .req_write(req_write),
    .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr), .dwait(dwait), .dstore(dstore), .snp_idx(snp_idx),
    .way_tag(way_tag), .way_valid(way_valid), .way_dirty(way_dirty), .way_data(way_data),
    .upd_en(upd_en), .upd_idx(upd_idx), .upd_way(upd_way), .upd_valid(upd_valid),
    .snp_busy(snp_busy), .link_valid(link_valid), .link_addr(link_addr), .link_clr(link_clr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Frame arrays presented at the set named by the snooped address.
  assign cur_set = ccsnoopaddr[5:3];
  always_comb begin
    way_tag = '0; way_valid = '0; way_dirty = '0; way_data = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      way_tag[w*TAGW +: TAGW] = f_tag[cur_set][w];
      way_valid[w]            = f_valid[cur_set][w];
      way_dirty[w]            = f_dirty[cur_set][w];
      for (int k = 0; k < 2; k++) way_data[(w*2+k)*32 +: 32] = f_data[cur_set][w][k];
    end
  end

  function automatic void model_lookup(input logic [31:0] a, output bit hit, output int way, output bit mod);
    hit = 0; way = 0; mod = 0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (!hit && f_valid[a[5:3]][w] && (f_tag[a[5:3]][w] == a[31:6])) begin
        hit = 1; way = w; mod = f_dirty[a[5:3]][w];
      end
    end
  endfunction

  task automatic clear_frames();
    for (int s = 0; s < int'(SETS); s++)
      for (int w = 0; w < int'(WAYS); w++) begin
        f_tag[s][w] = '0; f_valid[s][w] = 0; f_dirty[s][w] = 0;
        f_data[s][w][0] = '0; f_data[s][w][1] = '0;
      end
  endtask

  task automatic set_frame(input int s, input int w, input logic [TAGW-1:0] t, input logic v, input logic d);
    f_tag[s][w] = t; f_valid[s][w] = v; f_dirty[s][w] = d;
    f_data[s][w][0] = {8'hD0, 8'(s), 8'(w), 8'h00} ^ 32'($urandom_range(0, 255) << 8);
    f_data[s][w][1] = {8'hD1, 8'(s), 8'(w), 8'h04} ^ 32'($urandom_range(0, 255) << 8);
  endtask

  // One whole snoop from ccwait rise to return to idle, checked every cycle.
  task automatic run_snoop(input string nm, input logic [31:0] a, input logic inv,
                           input logic lv, input logic [31:0] la, input bit abort1, input bit rnd);
    bit hit, mod, match, cur_inv, exp_clr, cleared;
    int hw, acc, cyc;
    logic [2:0] s;
    s = a[5:3];
    model_lookup(a, hit, hw, mod);
    match = lv && (la[31:3] == a[31:3]);
    cur_inv = inv;
    cleared = 0;
    link_valid = lv; link_addr = la; ccsnoopaddr = {a[31:3], 3'b000};
    ccinv = inv; dwait = 1'b1; ccwait = 1'b1;
    @(negedge CLK);
    exp_clr = !hit && inv && match;
    n_cmp++; if (ccwrite !== mod) begin n_mis++; $display("FAIL %s snoop_ccwrite got %0b want %0b", nm, ccwrite, mod); end
    n_cmp++; if (snp_idx !== s) begin n_mis++; $display("FAIL %s snp_idx got %0d want %0d", nm, snp_idx, s); end
    n_cmp++; if (link_clr !== exp_clr) begin n_mis++; $display("FAIL %s idle_link_clr got %0b want %0b", nm, link_clr, exp_clr); end
    n_cmp++; if ({upd_en, snp_busy} !== 2'b00) begin n_mis++; $display("FAIL %s idle_upd_busy got %b want 00", nm, {upd_en, snp_busy}); end
    if (exp_clr) cleared = 1;
    @(posedge CLK); #1;
    if (mod) begin
      acc = 0; cyc = 0;
      while (acc < 2) begin
        if (abort1 && acc == 1) begin
          ccwait = 1'b0; dwait = 1'b1;
        end else begin
          dwait = rnd ? ((cyc < 6) ? logic'($urandom_range(0, 1)) : 1'b0) : ((cyc == 0) ? 1'b1 : 1'b0);
          ccsnoopaddr = {a[31:3], 1'(acc), 2'b00};
        end
        if (rnd && ($urandom_range(0, 3) == 0)) ccinv = 1'b1;
        cur_inv = cur_inv | ccinv;
        @(negedge CLK);
        n_cmp++; if ({ccwrite, snp_busy, upd_en} !== 3'b110) begin n_mis++; $display("FAIL %s supply_flags got %b want 110", nm, {ccwrite, snp_busy, upd_en}); end
        if (ccwait) begin
          n_cmp++;
          if (dstore !== f_data[s][hw][ccsnoopaddr[2]]) begin
            n_mis++; $display("FAIL %s dstore got %h want %h", nm, dstore, f_data[s][hw][ccsnoopaddr[2]]);
          end
          if (!dwait) acc++;
        end
        @(posedge CLK); #1;
        cyc++;
        if (!ccwait) break;
      end
    end
    dwait = 1'b1;
    if (hit && (mod || inv)) begin
      @(negedge CLK);
      exp_clr = lv && cur_inv && match;
      n_cmp++; if ({upd_en, snp_busy} !== 2'b11) begin n_mis++; $display("FAIL %s update_en_busy got %b want 11", nm, {upd_en, snp_busy}); end
      n_cmp++; if (upd_idx !== s || upd_way !== WAYW'(hw)) begin n_mis++; $display("FAIL %s update_frame got %0d/%0d want %0d/%0d", nm, upd_idx, upd_way, s, hw); end
      n_cmp++; if (upd_valid !== !cur_inv) begin n_mis++; $display("FAIL %s upd_valid got %0b want %0b", nm, upd_valid, !cur_inv); end
      n_cmp++; if (link_clr !== exp_clr) begin n_mis++; $display("FAIL %s update_link_clr got %0b want %0b", nm, link_clr, exp_clr); end
      f_dirty[s][hw] = 1'b0;
      f_valid[s][hw] = !cur_inv;
      if (exp_clr) cleared = 1;
      @(posedge CLK); #1;
    end else begin
      @(negedge CLK);
      n_cmp++; if ({upd_en, link_clr, snp_busy} !== 3'b000) begin n_mis++; $display("FAIL %s done_quiet got %b want 000", nm, {upd_en, link_clr, snp_busy}); end
      @(posedge CLK); #1;
    end
    ccwait = 1'b0; ccinv = 1'b0;
    if (cleared) link_valid = 1'b0;
    @(negedge CLK);
    n_cmp++; if ({upd_en, link_clr, snp_busy} !== 3'b000) begin n_mis++; $display("FAIL %s release_quiet got %b want 000", nm, {upd_en, link_clr, snp_busy}); end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    req_trans = 1'b1; req_write = 1'b1;
    @(negedge CLK);
    n_cmp++; if ({upd_en, link_clr, snp_busy} !== 3'b000) begin n_mis++; $display("FAIL reset_ctrl got %b want 000", {upd_en, link_clr, snp_busy}); end
    n_cmp++; if (dstore !== 32'h0) begin n_mis++; $display("FAIL reset_dstore got %h want 0", dstore); end
    n_cmp++; if ({cctrans, ccwrite} !== 2'b11) begin n_mis++; $display("FAIL reset_passthru got %b want 11", {cctrans, ccwrite}); end
    @(posedge CLK); #1;
    RST = 1'b0; req_trans = 1'b0; req_write = 1'b0;
    @(negedge CLK);
    n_cmp++; if ({cctrans, ccwrite} !== 2'b00) begin n_mis++; $display("FAIL reset_idle_bus got %b want 00", {cctrans, ccwrite}); end
    @(posedge CLK); #1;
  endtask

  task automatic test_modified_read();
    set_frame(1, 1, 26'd1, 1'b1, 1'b1);
    set_frame(1, 0, 26'd5, 1'b1, 1'b0);
    run_snoop("mod_read", 32'h0000_0048, 1'b0, 1'b0, 32'h0, 0, 0);
  endtask

  task automatic test_modified_inv_link();
    f_dirty[1][1] = 1'b1;
    run_snoop("mod_inv_link", 32'h0000_0048, 1'b1, 1'b1, 32'h0000_004C, 0, 0);
  endtask

  task automatic test_clean_inv();
    f_valid[1][1] = 1'b1; f_dirty[1][1] = 1'b0;
    run_snoop("clean_inv", 32'h0000_0048, 1'b1, 1'b0, 32'h0, 0, 0);
  endtask

  task automatic test_miss();
    run_snoop("miss", 32'h0000_0F48, 1'b0, 1'b1, 32'h0000_0F48, 0, 0);
    run_snoop("miss_inv_link", 32'h0000_0F48, 1'b1, 1'b1, 32'h0000_0F4C, 0, 0);
  endtask

  task automatic test_forward();
    req_trans = 1'b1; req_write = 1'b1; ccwait = 1'b0;
    @(negedge CLK);
    n_cmp++; if ({cctrans, ccwrite} !== 2'b11) begin n_mis++; $display("FAIL fwd_busrdx got %b want 11", {cctrans, ccwrite}); end
    @(posedge CLK); #1;
    run_snoop("fwd_miss", 32'h0000_01F8, 1'b0, 1'b0, 32'h0, 0, 0);
    @(negedge CLK);
    n_cmp++; if (ccwrite !== 1'b1) begin n_mis++; $display("FAIL fwd_resume got %0b want 1", ccwrite); end
    @(posedge CLK); #1;
    req_trans = 1'b1; req_write = 1'b0;
    @(negedge CLK);
    n_cmp++; if ({cctrans, ccwrite} !== 2'b10) begin n_mis++; $display("FAIL fwd_busrd got %b want 10", {cctrans, ccwrite}); end
    @(posedge CLK); #1;
    req_trans = 1'b0;
  endtask

  task automatic test_lowest_way();
    set_frame(3, 0, 26'd9, 1'b1, 1'b0);
    set_frame(3, 1, 26'd9, 1'b1, 1'b1);
    run_snoop("lowest_way_inv", 32'h0000_0258, 1'b1, 1'b0, 32'h0, 0, 0);
    run_snoop("second_way_mod", 32'h0000_0258, 1'b0, 1'b0, 32'h0, 0, 0);
  endtask

  task automatic test_abort();
    set_frame(4, 0, 26'd2, 1'b1, 1'b1);
    run_snoop("abort", 32'h0000_00A0, 1'b0, 1'b0, 32'h0, 1, 0);
  endtask

  task automatic test_short_pulse();
    set_frame(5, 1, 26'd4, 1'b1, 1'b0);
    link_valid = 1'b0;
    @(negedge CLK); #3;
    ccsnoopaddr = 32'h0000_0128; ccinv = 1'b1; ccwait = 1'b1; dwait = 1'b1;
    @(posedge CLK); #1;
    ccwait = 1'b0; ccinv = 1'b0;
    @(negedge CLK);
    n_cmp++; if ({upd_en, upd_valid, upd_way, upd_idx} !== {1'b1, 1'b0, 1'b1, 3'd5}) begin
      n_mis++; $display("FAIL short_pulse_update got %b want 10_1_101", {upd_en, upd_valid, upd_way, upd_idx});
    end
    f_valid[5][1] = 1'b0;
    @(posedge CLK); #1;
    @(negedge CLK);
    n_cmp++; if ({upd_en, snp_busy} !== 2'b00) begin n_mis++; $display("FAIL short_pulse_done got %b want 00", {upd_en, snp_busy}); end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset_mid_supply();
    set_frame(2, 0, 26'd7, 1'b1, 1'b1);
    link_valid = 1'b0;
    ccsnoopaddr = 32'h0000_01D0; ccinv = 1'b0; dwait = 1'b1; ccwait = 1'b1;
    @(posedge CLK); #1;
    dwait = 1'b0;
    @(negedge CLK);
    n_cmp++; if (dstore !== f_data[2][0][0]) begin n_mis++; $display("FAIL rst_mid_word0 got %h want %h", dstore, f_data[2][0][0]); end
    @(posedge CLK); #1;
    dwait = 1'b1;
    #2 RST = 1'b1; ccwait = 1'b0;
    #1;
    n_cmp++; if ({upd_en, snp_busy, link_clr, ccwrite} !== 4'b0000 || dstore !== 32'h0) begin
      n_mis++; $display("FAIL rst_mid_outputs got %b/%h want 0000/0", {upd_en, snp_busy, link_clr, ccwrite}, dstore);
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    n_cmp++; if ({upd_en, snp_busy} !== 2'b00) begin n_mis++; $display("FAIL rst_mid_after got %b want 00", {upd_en, snp_busy}); end
    @(posedge CLK); #1;
    run_snoop("after_reset", 32'h0000_01D0, 1'b0, 1'b0, 32'h0, 0, 0);
  endtask

  task automatic test_random();
    logic [31:0] a, la;
    for (int s = 0; s < int'(SETS); s++)
      for (int w = 0; w < int'(WAYS); w++)
        set_frame(s, w, 26'($urandom_range(0, 3)), logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)));
    for (int n = 0; n < 40; n++) begin
      a  = {26'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'b000};
      la = ($urandom_range(0, 1) != 0) ? (a | 32'($urandom_range(0, 1) << 2)) : $urandom;
      run_snoop($sformatf("rand%0d", n), a, logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
                la, ($urandom_range(0, 4) == 0), 1);
      if ($urandom_range(0, 1) != 0)
        set_frame($urandom_range(0, 7), $urandom_range(0, 1), 26'($urandom_range(0, 3)), 1'b1, 1'b1);
    end
  endtask

  initial begin
    RST = 1'b1; req_trans = 1'b0; req_write = 1'b0; ccwait = 1'b0; ccinv = 1'b0;
    ccsnoopaddr = 32'h0; dwait = 1'b1; link_valid = 1'b0; link_addr = 32'h0;
    clear_frames();
    test_reset();
    test_modified_read();
    test_modified_inv_link();
    test_clean_inv();
    test_miss();
    test_forward();
    test_lowest_way();
    test_abort();
    test_short_pulse();
    test_reset_mid_supply();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
